pattern_sequencer: RTL and testbench
====================================

Name: pattern_sequencer

Overview:
Programmable step sequencer that drives the four synth voices: square 1, square 2, triangle 1 and triangle 2. It replaces hard-coded per-demo case tables with a writable pattern memory of STEPS steps. Each step holds a 6-bit note index and a gate bit per channel. A tempo counter advances the step index; per-channel note/gate outputs feed the base_freq_genx64 note inputs and the generator enables.

Parameters:
STEPS, 16, pattern length capacity; power of 2; step index width SW = log2(STEPS).
TICK_DIV, 6000000, clk cycles per step (≈1/8 s at 50 MHz); minimum 2.
NOTE_W, 6, note index width; 0 = silence by convention.

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin/resume playback
stop  in  1  pulse: halt playback, return to step 0
pause  in  1  pulse: freeze at current step
last_step  in  SW  index of final step before wrap; sampled at each wrap
wr_en  in  1  pattern write strobe
wr_step  in  SW  step address for write
wr_ch  in  2  channel for write (0=sq1, 1=sq2, 2=tr1, 3=tr2)
wr_note  in  NOTE_W  note written
wr_gate  in  1  gate written
note0..note3  out  NOTE_W  per-channel note index (registered)
gate  out  4  per-channel enable (registered), bit n = channel n
step_idx  out  SW  step currently sounding
step_strobe  out  1  one-cycle pulse on the cycle outputs change to a new step
running  out  1  high in RUN
beat_led  out  1  toggles on every step_strobe

Behaviour:
- Reset (async, rst_n=0): state IDLE, tick counter 0, step_idx 0, note0..3 = 0, gate = 0, step_strobe 0, beat_led 0. Pattern memory is NOT cleared by reset; contents are undefined until written.
- States:
  - IDLE: outputs gate=0, notes hold their last value, step_idx=0.
  - RUN: tick counter counts.
  - PAUSED: counter and step frozen, gate forced 0, notes held.
- Transitions and command priority:
  - Priority when commands coincide: stop > pause > start.
  - stop from any state → IDLE next cycle: counter 0, step_idx 0, gate 0.
  - IDLE + start → RUN: step 0 is loaded on the following cycle with step_strobe=1, counter restarts at 0.
  - RUN + pause → PAUSED.
  - PAUSED + start → RUN: current step is reloaded with step_strobe=1 and the counter resumes from its frozen value.
  - start in RUN is ignored; pause in IDLE/PAUSED is ignored.
- Step advance:
  - In RUN the counter runs 0..TICK_DIV-1.
  - At terminal count, next = (step_idx == last_step) ? 0 : step_idx+1; if step_idx > last_step (length shortened mid-play), next = 0.
  - Next cycle: step_idx, all notes and gates update together; step_strobe=1; beat_led toggles.
  - Step period is exactly TICK_DIV cycles. Latency from start to first strobe is 1 cycle.
- Note hold: each channel updates note from memory every step regardless of gate. A step with gate=0 still loads its note, so a rest step may carry a note for glide/portamento preparation.
- Memory write: synchronous on clk when wr_en=1, legal in any state.
  - A write to the step being loaded on the same cycle as a load delivers the OLD data to the outputs; the new data takes effect on the next visit.
  - Writes never disturb the current outputs directly.
- Widths: counter width ceil(log2(TICK_DIV)); no arithmetic beyond increment and compare; step wrap is explicit, not modular overflow.

Test Plan:
- Use TICK_DIV=4, STEPS=16 for all scenarios.
- Reset, write step0 ch0 = note 41 gate 1, step1 ch0 = note 46 gate 0, last_step=1, pulse start → strobe at cycle 1 with note0=41, gate[0]=1; at cycle 5, note0=46, gate[0]=0; at cycle 9, note0=41 again (wrap); beat_led toggles each strobe.
- Running with last_step=15 at step 9, set last_step=3 → next step is 0, then 0..3 loop.
- Pause at step 2, hold 20 cycles → step_idx stays 2, gate=0, no strobes. Then start → step 2 reloaded with strobe, and the next advance occurs after the remaining ticks of the frozen count.
- start, pause and stop asserted in the same cycle while in RUN → IDLE, step_idx 0, gate 0, running 0.
- Write to step 1 ch2 on the exact cycle step 1 loads → old note is output; the new note appears on the next pass through step 1.
- Assert rst_n low mid-step, asynchronously between clock edges → outputs 0 immediately, state IDLE. Pattern memory is retained, so start replays the previously written notes.

Source files
------------

// File: rtl/pattern_sequencer.sv
// Four-voice step sequencer: writable note/gate pattern memory played at one step per TICK_DIV clocks.
// Start-to-first-strobe latency is 1 cycle; commands are single-cycle pulses with no backpressure.
module pattern_sequencer #(
  parameter int STEPS    = 16,
  parameter int TICK_DIV = 6000000,
  parameter int NOTE_W   = 6,
  localparam int SW      = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [SW-1:0]     last_step,
  input  logic              wr_en,
  input  logic [SW-1:0]     wr_step,
  input  logic [1:0]        wr_ch,
  input  logic [NOTE_W-1:0] wr_note,
  input  logic              wr_gate,
  output logic [NOTE_W-1:0] note0,
  output logic [NOTE_W-1:0] note1,
  output logic [NOTE_W-1:0] note2,
  output logic [NOTE_W-1:0] note3,
  output logic [3:0]        gate,
  output logic [SW-1:0]     step_idx,
  output logic              step_strobe,
  output logic              running,
  output logic              beat_led
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM     = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [SW-1:0] STEP_ONE = SW'(1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [SW-1:0]       step_nxt;
  logic                load;
  logic                gate_clr;

  logic [NOTE_W-1:0]   note_mem [STEPS][4];
  logic [3:0]          gate_mem [STEPS];

  // Pattern memory is deliberately not reset; it survives rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      note_mem[wr_step][wr_ch] <= wr_note;
      gate_mem[wr_step][wr_ch] <= wr_gate;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    step_nxt  = step_idx;
    load      = 1'b0;
    gate_clr  = 1'b0;
    if (stop) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      step_nxt  = '0;
      gate_clr  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
            step_nxt  = '0;
            load      = 1'b1;
          end
        end
        RUN: begin
          if (pause) begin
            state_nxt = PAUSED;
            gate_clr  = 1'b1;
          end else if (cnt == TERM) begin
            cnt_nxt  = '0;
            // >= also catches a pattern shortened below the current step
            step_nxt = (step_idx >= last_step) ? '0 : step_idx + STEP_ONE;
            load     = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        PAUSED: begin
          if (start) begin
            state_nxt = RUN;
            load      = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      step_idx    <= '0;
      note0       <= '0;
      note1       <= '0;
      note2       <= '0;
      note3       <= '0;
      gate        <= '0;
      step_strobe <= 1'b0;
      beat_led    <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      step_idx    <= step_nxt;
      step_strobe <= load;
      // Memory read uses pre-write contents, so a same-cycle write shows up on the next visit.
      if (load) begin
        note0    <= note_mem[step_nxt][0];
        note1    <= note_mem[step_nxt][1];
        note2    <= note_mem[step_nxt][2];
        note3    <= note_mem[step_nxt][3];
        gate     <= gate_mem[step_nxt];
        beat_led <= ~beat_led;
      end else if (gate_clr) begin
        gate <= '0;
      end
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with TICK_DIV=4, STEPS=16.
module tb_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic [3:0] last_step = 4'd0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_step = 4'd0;
  logic [1:0] wr_ch = 2'd0;
  logic [5:0] wr_note = 6'd0;
  logic       wr_gate = 1'b0;
  logic [5:0] note0, note1, note2, note3;
  logic [3:0] gate;
  logic [3:0] step_idx;
  logic       step_strobe, running, beat_led;

  int n_pass = 0;
  int n_total = 0;

  logic [5:0] m_note [16][4];
  logic       m_gate [16][4];

  pattern_sequencer #(.STEPS(16), .TICK_DIV(4), .NOTE_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .last_step(last_step), .wr_en(wr_en), .wr_step(wr_step), .wr_ch(wr_ch),
    .wr_note(wr_note), .wr_gate(wr_gate),
    .note0(note0), .note1(note1), .note2(note2), .note3(note3),
    .gate(gate), .step_idx(step_idx), .step_strobe(step_strobe),
    .running(running), .beat_led(beat_led)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [3:0] exp_gate(input int s);
    return {m_gate[s][3], m_gate[s][2], m_gate[s][1], m_gate[s][0]};
  endfunction

  task automatic write_cell(input int s, input int ch, input int n, input logic g);
    wr_en = 1'b1; wr_step = 4'(s); wr_ch = 2'(ch); wr_note = 6'(n); wr_gate = g;
    tick(1);
    wr_en = 1'b0;
    m_note[s][ch] = 6'(n);
    m_gate[s][ch] = g;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_total++; if (step_idx !== 4'd0) $display("FAIL reset_step: got %0d want 0", step_idx); else n_pass++;
    n_total++; if ({note0, note1, note2, note3} !== 24'd0) $display("FAIL reset_notes: got %h want 0", {note0, note1, note2, note3}); else n_pass++;
    n_total++; if (gate !== 4'd0) $display("FAIL reset_gate: got %b want 0000", gate); else n_pass++;
    n_total++; if ({step_strobe, running, beat_led} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {step_strobe, running, beat_led}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic load_pattern();
    for (int s = 0; s < 16; s++)
      for (int c = 0; c < 4; c++)
        write_cell(s, c, s * 4 + c, logic'((s + c) % 2));
    write_cell(0, 0, 41, 1'b1);
    write_cell(1, 0, 46, 1'b0);
  endtask

  task automatic test_basic();
    int strobes;
    last_step = 4'd1;
    pulse_start();
    n_total++; if (step_strobe !== 1'b1) $display("FAIL basic_first_strobe: got %b want 1", step_strobe); else n_pass++;
    n_total++; if (note0 !== 6'd41 || gate[0] !== 1'b1) $display("FAIL basic_step0: got note0=%0d g0=%b want 41/1", note0, gate[0]); else n_pass++;
    n_total++; if (gate !== exp_gate(0)) $display("FAIL basic_gate0: got %b want %b", gate, exp_gate(0)); else n_pass++;
    n_total++; if (running !== 1'b1 || beat_led !== 1'b1) $display("FAIL basic_run_beat: got run=%b beat=%b want 1/1", running, beat_led); else n_pass++;
    strobes = 0;
    for (int i = 0; i < 3; i++) begin tick(1); strobes += int'(step_strobe); end
    n_total++; if (strobes != 0) $display("FAIL basic_gap: got %0d strobes want 0", strobes); else n_pass++;
    tick(1);
    n_total++; if (step_strobe !== 1'b1 || step_idx !== 4'd1) $display("FAIL basic_adv1: got strobe=%b step=%0d want 1/1", step_strobe, step_idx); else n_pass++;
    n_total++; if (note0 !== 6'd46 || gate[0] !== 1'b0 || beat_led !== 1'b0) $display("FAIL basic_step1: got note0=%0d g0=%b beat=%b want 46/0/0", note0, gate[0], beat_led); else n_pass++;
    tick(4);
    n_total++; if (step_idx !== 4'd0 || note0 !== 6'd41 || beat_led !== 1'b1) $display("FAIL basic_wrap: got step=%0d note0=%0d beat=%b want 0/41/1", step_idx, note0, beat_led); else n_pass++;
  endtask

  task automatic test_shorten();
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    last_step = 4'd15;
    tick(36);
    n_total++; if (step_idx !== 4'd9 || note1 !== m_note[9][1]) $display("FAIL shorten_at9: got step=%0d note1=%0d want 9/%0d", step_idx, note1, m_note[9][1]); else n_pass++;
    last_step = 4'd3;
    for (int i = 0; i < 5; i++) begin
      tick(4);
      n_total++;
      if (step_idx !== 4'(exp_seq[i]) || note3 !== m_note[exp_seq[i]][3])
        $display("FAIL shorten_seq%0d: got step=%0d note3=%0d want %0d/%0d", i, step_idx, note3, exp_seq[i], m_note[exp_seq[i]][3]);
      else n_pass++;
    end
  endtask

  task automatic test_pause();
    int strobes;
    int moved;
    tick(9);
    pause = 1'b1;
    tick(1);
    pause = 1'b0;
    n_total++; if (step_idx !== 4'd2 || gate !== 4'd0 || running !== 1'b0) $display("FAIL pause_enter: got step=%0d gate=%b run=%b want 2/0000/0", step_idx, gate, running); else n_pass++;
    strobes = 0; moved = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      strobes += int'(step_strobe);
      if (step_idx !== 4'd2 || gate !== 4'd0) moved++;
    end
    n_total++; if (strobes != 0 || moved != 0) $display("FAIL pause_hold: got strobes=%0d changes=%0d want 0/0", strobes, moved); else n_pass++;
    pulse_start();
    n_total++; if (step_strobe !== 1'b1 || step_idx !== 4'd2 || gate !== exp_gate(2)) $display("FAIL pause_resume: got strobe=%b step=%0d gate=%b want 1/2/%b", step_strobe, step_idx, gate, exp_gate(2)); else n_pass++;
    strobes = 0;
    for (int i = 0; i < 2; i++) begin tick(1); strobes += int'(step_strobe); end
    n_total++; if (strobes != 0) $display("FAIL pause_early: got %0d strobes want 0", strobes); else n_pass++;
    tick(1);
    n_total++; if (step_strobe !== 1'b1 || step_idx !== 4'd3) $display("FAIL pause_remaining: got strobe=%b step=%0d want 1/3", step_strobe, step_idx); else n_pass++;
  endtask

  task automatic test_priority();
    start = 1'b1; pause = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; pause = 1'b0; stop = 1'b0;
    n_total++; if (running !== 1'b0 || step_idx !== 4'd0 || gate !== 4'd0) $display("FAIL prio_idle: got run=%b step=%0d gate=%b want 0/0/0000", running, step_idx, gate); else n_pass++;
    n_total++; if (note0 !== m_note[3][0] || step_strobe !== 1'b0) $display("FAIL prio_hold: got note0=%0d strobe=%b want %0d/0", note0, step_strobe, m_note[3][0]); else n_pass++;
    tick(6);
    n_total++; if (running !== 1'b0 || step_idx !== 4'd0) $display("FAIL prio_stays: got run=%b step=%0d want 0/0", running, step_idx); else n_pass++;
  endtask

  task automatic test_write_collision();
    logic [5:0] old_note;
    logic [3:0] old_gate;
    old_note = m_note[1][2];
    old_gate = exp_gate(1);
    pulse_start();
    tick(3);
    wr_en = 1'b1; wr_step = 4'd1; wr_ch = 2'd2; wr_note = 6'd55; wr_gate = 1'b0;
    tick(1);
    wr_en = 1'b0;
    m_note[1][2] = 6'd55;
    m_gate[1][2] = 1'b0;
    n_total++; if (step_idx !== 4'd1 || note2 !== old_note || gate !== old_gate) $display("FAIL coll_old: got step=%0d note2=%0d gate=%b want 1/%0d/%b", step_idx, note2, gate, old_note, old_gate); else n_pass++;
    tick(16);
    n_total++; if (step_idx !== 4'd1 || note2 !== 6'd55 || gate !== exp_gate(1)) $display("FAIL coll_new: got step=%0d note2=%0d gate=%b want 1/55/%b", step_idx, note2, gate, exp_gate(1)); else n_pass++;
  endtask

  task automatic test_async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    n_total++; if (step_idx !== 4'd0 || gate !== 4'd0 || note0 !== 6'd0 || note2 !== 6'd0) $display("FAIL areset_out: got step=%0d gate=%b note0=%0d note2=%0d want 0", step_idx, gate, note0, note2); else n_pass++;
    n_total++; if ({running, beat_led, step_strobe} !== 3'b000) $display("FAIL areset_flags: got %b want 000", {running, beat_led, step_strobe}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    n_total++; if (running !== 1'b0) $display("FAIL areset_idle: got run=%b want 0", running); else n_pass++;
    pulse_start();
    n_total++; if (step_idx !== 4'd0 || note0 !== 6'd41 || gate !== exp_gate(0)) $display("FAIL areset_replay0: got step=%0d note0=%0d gate=%b want 0/41/%b", step_idx, note0, gate, exp_gate(0)); else n_pass++;
    tick(4);
    n_total++; if (step_idx !== 4'd1 || note0 !== 6'd46 || note2 !== 6'd55) $display("FAIL areset_replay1: got step=%0d note0=%0d note2=%0d want 1/46/55", step_idx, note0, note2); else n_pass++;
  endtask

  initial begin
    test_reset();
    load_pattern();
    test_basic();
    test_shorten();
    test_pause();
    test_priority();
    test_write_collision();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
